tinker_mem_arbiter: RTL and testbench

//  Shares one single-ported memory between the core's instruction-fetch requester and its load/store/call/return requester.

---
 rtl/tinker_mem_pkg.sv | 24 ++
 rtl/tinker_mem_prio.sv | 25 ++
 rtl/tinker_mem_arbiter.sv | 164 ++++++++++++++++
 tb/tb_tinker_mem_arbiter.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tinker_mem_pkg : shared types and widths for the tinker memory arbiter
// Revision: 1.0
// ----------------------------------------------------------------------------
package tinker_mem_pkg;

  localparam int TINKER_ADDR_W = 32;
  localparam int TINKER_DATA_W = 64;
  localparam int TINKER_INST_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/tinker_mem_prio.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tinker_mem_prio : data-first priority select with fetch starvation override
// Revision: 1.0
// ----------------------------------------------------------------------------
module tinker_mem_prio
  import tinker_mem_pkg::*;
(
  input  logic       f_req,
  input  logic       d_req,
  input  logic       starve,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (d_req && !(f_req && starve)) begin
      gnt[OWN_DATA] = 1'b1;
    end else if (f_req) begin
      gnt[OWN_FETCH] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tinker_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tinker_mem_arbiter : shares one single-ported memory between fetch and data
// Revision: 1.0
// ----------------------------------------------------------------------------
module tinker_mem_arbiter
  import tinker_mem_pkg::*;
#(
  parameter int ADDR_W       = TINKER_ADDR_W,
  parameter int DATA_W       = TINKER_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     f_req,
  input  logic [ADDR_W-1:0]        f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [TINKER_INST_W-1:0] f_rdata,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [DATA_W-1:0]        d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [DATA_W-1:0]        d_rdata,
  output logic                     m_req,
  output logic                     m_we,
  output logic [ADDR_W-1:0]        m_addr,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_ack,
  input  logic [DATA_W-1:0]        m_rdata
);

  localparam int             SW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0]  LIMIT = SW'(STARVE_LIMIT);

  arb_state_t                 state_q, state_d;
  arb_owner_t                 owner_q, owner_d;
  logic [SW-1:0]              streak_q, streak_d;
  logic                       m_req_q, m_req_d;
  logic                       m_we_q, m_we_d;
  logic [ADDR_W-1:0]          m_addr_q, m_addr_d;
  logic [DATA_W-1:0]          m_wdata_q, m_wdata_d;
  logic                       f_rvalid_q, f_rvalid_d;
  logic [TINKER_INST_W-1:0]   f_rdata_q, f_rdata_d;
  logic                       d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]          d_rdata_q, d_rdata_d;

  logic [1:0] prio_gnt;
  logic       grant_ok;

  tinker_mem_prio u_prio (
    .f_req  (f_req),
    .d_req  (d_req),
    .starve (streak_q == LIMIT),
    .gnt    (prio_gnt)
  );

  // Grants are only offered in IDLE and are suppressed while reset is held.
  assign grant_ok = (state_q == ARB_IDLE) && !reset;
  assign f_gnt    = grant_ok && prio_gnt[OWN_FETCH];
  assign d_gnt    = grant_ok && prio_gnt[OWN_DATA];

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    m_req_d    = m_req_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    f_rvalid_d = 1'b0;
    f_rdata_d  = f_rdata_q;
    d_rvalid_d = 1'b0;
    d_rdata_d  = d_rdata_q;

    case (state_q)
      ARB_IDLE: begin
        if (d_gnt) begin
          owner_d   = OWN_DATA;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          state_d   = ARB_BUSY;
          // Streak counts data wins that happened while fetch was waiting.
          if (!f_req) begin
            streak_d = '0;
          end else if (streak_q != LIMIT) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (f_gnt) begin
          owner_d   = OWN_FETCH;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = f_addr;
          m_wdata_d = '0;
          streak_d  = '0;
          state_d   = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (m_ack) begin
          m_req_d = 1'b0;
          state_d = ARB_DONE;
          if (owner_q == OWN_DATA) begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = m_we_q ? '0 : m_rdata;
          end else begin
            f_rvalid_d = 1'b1;
            f_rdata_d  = m_rdata[TINKER_INST_W-1:0];
          end
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWN_FETCH;
      streak_q   <= '0;
      m_req_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      f_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      m_req_q    <= m_req_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
      f_rvalid_q <= f_rvalid_d;
      f_rdata_q  <= f_rdata_d;
      d_rvalid_q <= d_rvalid_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign m_req    = m_req_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign f_rvalid = f_rvalid_q;
  assign f_rdata  = f_rdata_q;
  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_tinker_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_tinker_mem_arbiter : scoreboard bench with a reference memory model
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_tinker_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_gnt;
  logic        f_rvalid;
  logic [31:0] f_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [63:0] d_rdata;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_ack;
  logic [63:0] m_rdata;

  tinker_mem_arbiter #(.ADDR_W(32), .DATA_W(64), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { bit own; logic [63:0] data; } exp_t;
  typedef struct { logic [31:0] a; logic w; logic [63:0] wd; } mop_t;
  exp_t        eq[$];
  mop_t        mq[$];
  logic [63:0] refmem [logic [31:0]];
  logic [63:0] respmem [logic [31:0]];
  bit          idle_m    = 1'b1;
  bit          pend_idle = 1'b0;
  int          streak_m  = 0;
  int          gnt_cyc   = 0;
  int          ack_cyc   = 0;
  string       glog      = "";

  function automatic logic [63:0] dflt(input logic [31:0] a);
    return {a ^ 32'h5A5A_C3C3, ~a + 32'd7};
  endfunction

  function automatic logic [63:0] ref_rd(input logic [31:0] a);
    return refmem.exists(a) ? refmem[a] : dflt(a);
  endfunction

  function automatic logic [63:0] resp_rd(input logic [31:0] a);
    return respmem.exists(a) ? respmem[a] : dflt(a);
  endfunction

  // Monitor: predicts grants, records expectations, checks returned data.
  initial begin
    bit   exp_d, exp_f;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("gnt_in_reset", {62'b0, d_gnt, f_gnt}, 64'd0);
        continue;
      end
      if (pend_idle) begin
        idle_m    = 1'b1;
        pend_idle = 1'b0;
      end
      exp_d = idle_m && d_req && !(f_req && streak_m == LIMIT);
      exp_f = idle_m && f_req && !exp_d;
      chk("gnt", {62'b0, d_gnt, f_gnt}, {62'b0, exp_d, exp_f});
      if (d_gnt) glog = {glog, "D"};
      if (f_gnt) glog = {glog, "F"};
      if (exp_d) begin
        mq.push_back('{a: d_addr, w: d_we, wd: d_wdata});
        if (d_we) begin
          refmem[d_addr] = d_wdata;
          eq.push_back('{own: 1'b1, data: 64'd0});
        end else begin
          eq.push_back('{own: 1'b1, data: ref_rd(d_addr)});
        end
        streak_m = f_req ? ((streak_m < LIMIT) ? streak_m + 1 : LIMIT) : 0;
      end else if (exp_f) begin
        mq.push_back('{a: f_addr, w: 1'b0, wd: 64'd0});
        eq.push_back('{own: 1'b0, data: {32'd0, ref_rd(f_addr)[31:0]}});
        streak_m = 0;
      end
      if (exp_d || exp_f) begin
        idle_m  = 1'b0;
        gnt_cyc = cyc;
      end
      if (f_rvalid || d_rvalid) begin
        pend_idle = 1'b1;
        if (eq.size() == 0) begin
          chk("unexpected_rvalid", {62'b0, d_rvalid, f_rvalid}, 64'd0);
        end else begin
          e = eq.pop_front();
          chk("rvalid_owner", {62'b0, d_rvalid, f_rvalid}, e.own ? 64'd2 : 64'd1);
          if (e.own) chk("d_rdata", d_rdata, e.data);
          else       chk("f_rdata", {32'd0, f_rdata}, e.data);
          chk("rvalid_latency", 64'(cyc), 64'(ack_cyc + 1));
        end
      end
    end
  end

  // Memory responder
  bit resp_en     = 1'b1;
  int fixed_delay = 0;
  int stray_mode  = 0;

  task automatic serve();
    logic [31:0] a;
    logic        w;
    logic [63:0] wd;
    int          dly;
    mop_t        m;
    a  = m_addr;
    w  = m_we;
    wd = m_wdata;
    chk("mreq_latency", 64'(cyc), 64'(gnt_cyc + 1));
    if (mq.size() == 0) begin
      chk("unexpected_mreq", 64'd1, 64'd0);
    end else begin
      m = mq.pop_front();
      chk("m_addr", {32'd0, a}, {32'd0, m.a});
      chk("m_we", {63'd0, w}, {63'd0, m.w});
      chk("m_wdata", wd, m.wd);
    end
    dly = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
    for (int k = 0; k < dly; k++) begin
      @(posedge clk); #2;
      chk("m_req_held", {63'd0, m_req}, 64'd1);
      chk("m_addr_stable", {32'd0, m_addr}, {32'd0, a});
      chk("m_wdata_stable", m_wdata, wd);
      chk("m_we_stable", {63'd0, m_we}, {63'd0, w});
    end
    m_ack   = 1'b1;
    m_rdata = w ? {$urandom, $urandom} | 64'd1 : resp_rd(a);
    if (w) respmem[a] = wd;
    ack_cyc = cyc;
    @(posedge clk); #2;
    chk("m_req_drop", {63'd0, m_req}, 64'd0);
    if (stray_mode == 1 || (stray_mode == 2 && $urandom_range(0, 1) == 1)) begin
      m_ack   = 1'b1;
      m_rdata = {$urandom, $urandom};
    end else begin
      m_ack = 1'b0;
    end
  endtask

  initial begin
    m_ack   = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (resp_en) begin
        m_ack = 1'b0;
        if (m_req === 1'b1) serve();
      end
    end
  end

  // Requester tasks
  task automatic issue_f(input logic [31:0] a);
    @(posedge clk); #2;
    f_req  = 1'b1;
    f_addr = a;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (f_gnt) return;
    end
    chk("issue_f_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue_d(input logic w, input logic [31:0] a, input logic [63:0] wd);
    @(posedge clk); #2;
    d_req   = 1'b1;
    d_we    = w;
    d_addr  = a;
    d_wdata = wd;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (d_gnt) return;
    end
    chk("issue_d_timeout", 64'd1, 64'd0);
  endtask

  task automatic pulse_f(input logic [31:0] a);
    @(posedge clk); #2;
    f_req  = 1'b1;
    f_addr = a;
    @(posedge clk); #2;
    f_req  = 1'b0;
  endtask

  task automatic drop_f();
    @(posedge clk); #2;
    f_req = 1'b0;
  endtask

  task automatic drop_d();
    @(posedge clk); #2;
    d_req = 1'b0;
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (idle_m && !pend_idle && eq.size() == 0 && mq.size() == 0 && !f_req && !d_req) return;
    end
    chk("quiet_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    f_req = 1'b1; f_addr = 32'h44; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88; d_wdata = '0;

    // Reset state, with both requesters asking
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_req", {63'd0, m_req}, 64'd0);
    chk("rst_m_addr", {32'd0, m_addr}, 64'd0);
    chk("rst_f_rvalid", {63'd0, f_rvalid}, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    @(posedge clk); #2;
    reset = 1'b0; f_req = 1'b0; d_req = 1'b0;

    // Single fetch, zero-wait memory
    refmem[32'h2000]  = 64'hDEADBEEF_12345678;
    respmem[32'h2000] = 64'hDEADBEEF_12345678;
    fixed_delay = 0;
    issue_f(32'h2000);
    drop_f();
    wait_quiet();
    chk("fetch_word", {32'd0, f_rdata}, 64'h12345678);

    // Reset in the middle of a transaction
    resp_en = 1'b0;
    issue_f(32'h3000);
    drop_f();
    @(posedge clk); #2;
    chk("busy_m_req", {63'd0, m_req}, 64'd1);
    #1 reset = 1'b1;
    #1;
    chk("arst_m_req", {63'd0, m_req}, 64'd0);
    chk("arst_m_addr", {32'd0, m_addr}, 64'd0);
    chk("arst_f_rdata", {32'd0, f_rdata}, 64'd0);
    chk("arst_gnt", {62'd0, d_gnt, f_gnt}, 64'd0);
    eq.delete(); mq.delete();
    idle_m = 1'b1; pend_idle = 1'b0; streak_m = 0;
    @(posedge clk); #2;
    reset   = 1'b0;
    m_ack   = 1'b1;
    m_rdata = 64'hFFFF_0000_FFFF_0000;
    @(posedge clk); #2;
    m_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2 resp_en = 1'b1;

    // Store then load at the same address
    fixed_delay = 1;
    issue_d(1'b1, 32'h10000, 64'h0123456789ABCDEF);
    issue_d(1'b0, 32'h10000, 64'h0);
    drop_d();
    wait_quiet();
    chk("load_back", d_rdata, 64'h0123456789ABCDEF);

    // Priority and starvation: both held high from the same cycle
    fixed_delay = -1;
    glog = "";
    fork
      begin
        for (int i = 0; i < 8; i++) issue_d(1'($urandom), 32'h100 + 32'(i * 8), {$urandom, $urandom});
        drop_d();
      end
      begin
        issue_f(32'h500);
        issue_f(32'h504);
        drop_f();
      end
    join
    wait_quiet();
    checks++;
    if (glog != "DDDDFDDDDF") begin
      errors++;
      $display("FAIL grant_order: got %s expected DDDDFDDDDF", glog);
    end

    // Slow memory, request arriving while busy, stray ack in DONE
    fixed_delay = 5;
    stray_mode  = 1;
    fork
      begin
        issue_d(1'b1, 32'h200, 64'hCAFE_F00D_1234_5678);
        drop_d();
      end
      begin
        repeat (2) @(posedge clk);
        issue_f(32'h400);
        drop_f();
      end
    join
    wait_quiet();
    stray_mode = 0;

    // Randomized traffic
    fixed_delay = -1;
    stray_mode  = 2;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          if ($urandom_range(0, 4) == 0) begin
            pulse_f($urandom & 32'h0000_FFFC);
          end else begin
            issue_f($urandom & 32'h0000_FFFC);
            drop_f();
          end
        end
      end
      begin
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(posedge clk);
          issue_d(1'($urandom), 32'h100 + 32'($urandom_range(0, 3) * 8), {$urandom, $urandom});
          drop_d();
        end
      end
    join
    wait_quiet();
    stray_mode = 0;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
